// File: rtl/generador_vectores_xy_if.sv
// Control/observation bundle between a sequencing controller and the X/Y
// stimulus generator that feeds the two-input gate block.
interface generador_vectores_xy_if;
  logic       start;
  logic       stop;
  logic       modo;
  logic       X;
  logic       Y;
  logic       valid;
  logic       nuevo;
  logic [1:0] vec_idx;
  logic       busy;
  logic       done;
  logic [7:0] pasadas;

  modport master (
    output start, stop, modo,
    input  X, Y, valid, nuevo, vec_idx, busy, done, pasadas
  );

  modport slave (
    input  start, stop, modo,
    output X, Y, valid, nuevo, vec_idx, busy, done, pasadas
  );
endinterface

// File: rtl/generador_vectores_xy.sv
// Sweeps the four (X,Y) operand pairs in binary or Gray order, holding each
// for HOLD_CYCLES cycles, for N_PASADAS sweeps (0 = until stop).
module generador_vectores_xy #(
  parameter int HOLD_CYCLES = 10,
  parameter int N_PASADAS   = 1,
  parameter int CW          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  generador_vectores_xy_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] HMAX = CW'(HOLD_CYCLES - 1);
  localparam logic [7:0]    NP   = 8'(N_PASADAS);

  state_t        st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n, nv;
  logic [7:0]    pas, pas_n, pas_inc;
  logic          x_q, x_n, y_q, y_n;
  logic          vld, vld_n, nuevo_q, nuevo_n;
  logic          busy_q, busy_n, done_q, done_n;
  logic          modo_q, modo_n;

  // Returns {Y,X} for sweep index i; g selects Gray order.
  function automatic logic [1:0] vec_of(input logic [1:0] i, input logic g);
    return g ? (i ^ {1'b0, i[1]}) : i;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      pas     <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      vld     <= 1'b0;
      nuevo_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      modo_q  <= 1'b0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      pas     <= pas_n;
      x_q     <= x_n;
      y_q     <= y_n;
      vld     <= vld_n;
      nuevo_q <= nuevo_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      modo_q  <= modo_n;
    end
  end

  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    idx_n   = idx;
    pas_n   = pas;
    x_n     = x_q;
    y_n     = y_q;
    vld_n   = vld;
    busy_n  = busy_q;
    modo_n  = modo_q;
    nuevo_n = 1'b0;
    done_n  = 1'b0;
    pas_inc = pas + 8'd1;
    nv      = vec_of(idx + 2'd1, modo_q);
    case (st)
      IDLE: begin
        x_n    = 1'b0;
        y_n    = 1'b0;
        vld_n  = 1'b0;
        busy_n = 1'b0;
        idx_n  = '0;
        cnt_n  = '0;
        // Vector 0 is (0,0) in both orders, so X/Y stay low on entry.
        if (bus.start && !bus.stop) begin
          st_n    = RUN;
          modo_n  = bus.modo;
          vld_n   = 1'b1;
          nuevo_n = 1'b1;
          busy_n  = 1'b1;
          pas_n   = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          st_n   = IDLE;
          vld_n  = 1'b0;
          busy_n = 1'b0;
          x_n    = 1'b0;
          y_n    = 1'b0;
          idx_n  = '0;
          cnt_n  = '0;
        end else if (cnt == HMAX) begin
          cnt_n      = '0;
          idx_n      = idx + 2'd1;
          {y_n, x_n} = nv;
          nuevo_n    = 1'b1;
          if (idx == 2'd3) begin
            pas_n = pas_inc;
            if (NP != 8'd0 && pas_inc == NP) begin
              st_n    = DONE;
              done_n  = 1'b1;
              busy_n  = 1'b0;
              vld_n   = 1'b0;
              nuevo_n = 1'b0;
              x_n     = 1'b0;
              y_n     = 1'b0;
              idx_n   = '0;
            end
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  assign bus.X       = x_q;
  assign bus.Y       = y_q;
  assign bus.valid   = vld;
  assign bus.nuevo   = nuevo_q;
  assign bus.vec_idx = idx;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pasadas = pas;

endmodule

// File: tb/tb_generador_vectores_xy.sv
// Directed bench: three generator instances (long-hold single sweep,
// Gray double sweep at hold 1, continuous at hold 1).
module tb_generador_vectores_xy;

  logic clk = 1'b0;
  logic rst_a, rst_g, rst_c;
  int   checks = 0;
  int   errors = 0;

  generador_vectores_xy_if if_a ();
  generador_vectores_xy_if if_g ();
  generador_vectores_xy_if if_c ();

  generador_vectores_xy #(.HOLD_CYCLES(10), .N_PASADAS(1), .CW(8))
    u_a (.clk(clk), .rst(rst_a), .bus(if_a));
  generador_vectores_xy #(.HOLD_CYCLES(1), .N_PASADAS(2), .CW(8))
    u_g (.clk(clk), .rst(rst_g), .bus(if_g));
  generador_vectores_xy #(.HOLD_CYCLES(1), .N_PASADAS(0), .CW(8))
    u_c (.clk(clk), .rst(rst_c), .bus(if_c));

  always #5 clk = ~clk;

  // Hand-derived (X,Y) per vector index.
  logic bin_x [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic bin_y [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic gry_x [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic gry_y [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  logic [7:0] obs, exp_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_g = 1'b1; rst_c = 1'b1;
    tick(); tick();
    rst_a = 1'b0; rst_g = 1'b0; rst_c = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      obs = {if_a.X, if_a.Y, if_a.valid, if_a.busy, if_a.done, if_g.busy, if_c.busy, if_g.valid};
      checks++;
      if (obs !== 8'd0 || if_a.pasadas !== 8'd0 || if_c.pasadas !== 8'd0) begin
        errors++;
        $display("FAIL reset_idle_c%0d got %b pas %0d want 0", c, obs, if_a.pasadas);
      end
    end
  endtask

  // Checks one full HOLD=10 binary sweep on instance a, cycles 1..42.
  task automatic sweep_a(input string nm, input int modo_flip_at);
    int j;
    for (int c = 1; c <= 40; c++) begin
      j = (c - 1) / 10;
      obs   = {if_a.X, if_a.Y, if_a.valid, if_a.nuevo, if_a.busy, if_a.done, if_a.vec_idx};
      exp_v = {bin_x[j], bin_y[j], 1'b1, ((c - 1) % 10 == 0), 1'b1, 1'b0, 2'(j)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s_c%0d got %b want %b", nm, c, obs, exp_v);
      end
      if (c == modo_flip_at) if_a.modo = ~if_a.modo;
      tick();
    end
    obs = {2'b00, if_a.X, if_a.Y, if_a.valid, if_a.nuevo, if_a.busy, if_a.done};
    checks++;
    if (obs !== 8'b0000_0001 || if_a.pasadas !== 8'd1) begin
      errors++;
      $display("FAIL %s_done got %b pas %0d want 00000001 pas 1", nm, obs, if_a.pasadas);
    end
    tick();
    checks++;
    if (if_a.done !== 1'b0 || if_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done got done %b busy %b want 0 0", nm, if_a.done, if_a.busy);
    end
  endtask

  task automatic test_binary();
    if_a.modo = 1'b0; if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    sweep_a("bin", 0);
  endtask

  task automatic test_gray();
    int j;
    if_g.modo = 1'b1; if_g.start = 1'b1;
    tick();
    if_g.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      j = (c - 1) % 4;
      obs   = {if_g.X, if_g.Y, if_g.valid, if_g.nuevo, if_g.busy, if_g.done, if_g.vec_idx};
      exp_v = {gry_x[j], gry_y[j], 4'b1110, 2'(j)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL gray_c%0d got %b want %b", c, obs, exp_v);
      end
      tick();
    end
    checks++;
    if (if_g.done !== 1'b1 || if_g.busy !== 1'b0 || if_g.valid !== 1'b0 || if_g.pasadas !== 8'd2) begin
      errors++;
      $display("FAIL gray_done got done %b busy %b pas %0d want 1 0 2", if_g.done, if_g.busy, if_g.pasadas);
    end
    tick();
    checks++;
    if (if_g.done !== 1'b0) begin
      errors++;
      $display("FAIL gray_after_done got done %b want 0", if_g.done);
    end
  endtask

  task automatic test_abort();
    int nd;
    if_a.modo = 1'b0; if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    checks++;
    if ({if_a.X, if_a.Y, if_a.vec_idx, if_a.busy} !== 5'b10011) begin
      errors++;
      $display("FAIL abort_pre got %b want 10011", {if_a.X, if_a.Y, if_a.vec_idx, if_a.busy});
    end
    if_a.stop = 1'b1;
    tick();
    if_a.stop = 1'b0;
    obs = {if_a.X, if_a.Y, if_a.valid, if_a.busy, if_a.done, if_a.nuevo, if_a.vec_idx};
    checks++;
    if (obs !== 8'd0 || if_a.pasadas !== 8'd0) begin
      errors++;
      $display("FAIL abort_idle got %b pas %0d want 0 pas 0", obs, if_a.pasadas);
    end
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (if_a.done || if_a.busy) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d active cycles want 0", nd);
    end
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    obs = {if_a.X, if_a.Y, if_a.valid, if_a.nuevo, if_a.busy, if_a.done, if_a.vec_idx};
    checks++;
    if (obs !== 8'b0011_1000) begin
      errors++;
      $display("FAIL abort_restart got %b want 00111000", obs);
    end
    for (int c = 1; c < 11; c++) tick();
    checks++;
    if ({if_a.X, if_a.Y, if_a.nuevo, if_a.vec_idx} !== 5'b10101) begin
      errors++;
      $display("FAIL abort_restart_v1 got %b want 10101", {if_a.X, if_a.Y, if_a.nuevo, if_a.vec_idx});
    end
    if_a.stop = 1'b1;
    tick();
    if_a.stop = 1'b0;
  endtask

  task automatic test_ignored();
    if_a.modo = 1'b0; if_a.start = 1'b1; if_a.stop = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (if_a.busy !== 1'b0 || if_a.valid !== 1'b0) begin
        errors++;
        $display("FAIL start_stop_idle_c%0d got busy %b valid %b want 0 0", c, if_a.busy, if_a.valid);
      end
    end
    if_a.stop = 1'b0;
    tick();
    // start stays high throughout; modo flips at cycle 5 and must not matter.
    sweep_a("held", 5);
    tick();
    checks++;
    if ({if_a.busy, if_a.nuevo, if_a.valid, if_a.vec_idx} !== 5'b11100) begin
      errors++;
      $display("FAIL held_rerun got %b want 11100", {if_a.busy, if_a.nuevo, if_a.valid, if_a.vec_idx});
    end
    if_a.start = 1'b0; if_a.stop = 1'b1;
    tick();
    if_a.stop = 1'b0; if_a.modo = 1'b0;
  endtask

  task automatic test_reset_midrun();
    if_a.modo = 1'b0; if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int c = 1; c < 21; c++) tick();
    checks++;
    if ({if_a.X, if_a.Y, if_a.vec_idx} !== 4'b0110) begin
      errors++;
      $display("FAIL rstmid_pre got %b want 0110", {if_a.X, if_a.Y, if_a.vec_idx});
    end
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    obs = {if_a.X, if_a.Y, if_a.valid, if_a.nuevo, if_a.busy, if_a.done, if_a.vec_idx};
    checks++;
    if (obs !== 8'd0 || if_a.pasadas !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_out got %b pas %0d want 0 pas 0", obs, if_a.pasadas);
    end
    tick();
    checks++;
    if (if_a.busy !== 1'b0 || if_a.valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle got busy %b valid %b want 0 0", if_a.busy, if_a.valid);
    end
  endtask

  task automatic test_continuous();
    int nd;
    nd = 0;
    if_c.modo = 1'b0; if_c.start = 1'b1;
    tick();
    if_c.start = 1'b0;
    for (int c = 1; c <= 1024; c++) begin
      if (if_c.done) nd++;
      if (c == 5) begin
        checks++;
        if (if_c.pasadas !== 8'd1) begin
          errors++;
          $display("FAIL cont_pas5 got %0d want 1", if_c.pasadas);
        end
      end
      if (c == 1024) begin
        checks++;
        if (if_c.pasadas !== 8'd255) begin
          errors++;
          $display("FAIL cont_pas1024 got %0d want 255", if_c.pasadas);
        end
      end
      tick();
    end
    checks++;
    if (if_c.pasadas !== 8'd0 || if_c.busy !== 1'b1 || nd != 0) begin
      errors++;
      $display("FAIL cont_wrap got pas %0d busy %b dones %0d want 0 1 0", if_c.pasadas, if_c.busy, nd);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_g = 1'b1; rst_c = 1'b1;
    if_a.start = 1'b0; if_a.stop = 1'b0; if_a.modo = 1'b0;
    if_g.start = 1'b0; if_g.stop = 1'b0; if_g.modo = 1'b0;
    if_c.start = 1'b0; if_c.stop = 1'b0; if_c.modo = 1'b0;
    #1;
    test_reset();
    test_binary();
    test_gray();
    test_abort();
    test_ignored();
    test_reset_midrun();
    test_continuous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/generador_vectores_xy.md
Name: generador_vectores_xy

Overview:
- Sequential stimulus source that sits directly upstream of the two-input logic-gate block and drives its X and Y inputs.
- Steps through all four (X,Y) combinations, in binary or Gray order, and holds each vector for a programmable number of cycles.
- Runs a programmable number of full sweeps, or runs continuously.
- Uses a start/stop/done handshake so a controller or testbench can sequence gate evaluation without hand-written delays.

Parameters:
- HOLD_CYCLES, 10: cycles each vector is held; legal range 1..255.
- N_PASADAS, 1: full 4-vector sweeps per run; 0 = continuous until stop.
- CW, 8: width of the internal hold counter; must satisfy HOLD_CYCLES <= 2^CW-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE only.
- stop  in  1  level; aborts a run.
- modo  in  1  0 = binary order, 1 = Gray order; sampled with start.
- X  out  1  registered operand X to the gate block.
- Y  out  1  registered operand Y to the gate block.
- valid  out  1  high while X/Y carry a vector of an active run.
- nuevo  out  1  1-cycle pulse on the first cycle of each vector.
- vec_idx  out  2  index (0..3) of the current vector within its sweep.
- busy  out  1  high while in RUN.
- done  out  1  1-cycle pulse when the last sweep completes.
- pasadas  out  8  completed sweeps in the current run.

Behaviour:
- All outputs are registered. rst=1 at an edge forces state=IDLE, X=0, Y=0, valid=0, nuevo=0, vec_idx=0, busy=0, done=0, pasadas=0 and hold counter=0. This applies from any state, including mid-run.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start=1 and stop=0 at edge k: next state RUN; modo is latched.
  - At edge k+1: vec_idx=0, X/Y=vector 0, valid=1, nuevo=1, busy=1, pasadas=0.
  - If start and stop are both 1, stop wins and the block stays in IDLE.
- Vector mapping (i = vec_idx):
  - Binary (modo=0): X=i[0], Y=i[1], giving (X,Y) = 00, 10, 01, 11.
  - Gray (modo=1): g = i ^ (i>>1), X=g[0], Y=g[1], giving (X,Y) = 00, 10, 11, 01.
- RUN:
  - The hold counter counts 0..HOLD_CYCLES-1. Vector j of a sweep first appears at edge k+1+j*HOLD_CYCLES, with nuevo=1 on that cycle only.
  - When the counter reaches HOLD_CYCLES-1, vec_idx advances and wraps 3 -> 0.
  - On the 3 -> 0 wrap, pasadas increments; it wraps 255 -> 0 in continuous mode.
  - If N_PASADAS != 0 and the incremented value equals N_PASADAS, go to DONE instead of wrapping.
  - HOLD_CYCLES=1 gives a new vector and a nuevo pulse every cycle.
  - start is ignored in RUN. A change on modo during RUN is ignored.
- DONE (exactly one cycle):
  - done=1, busy=0, valid=0, nuevo=0, X=Y=0; pasadas holds its final value.
  - Next state is IDLE unconditionally. start asserted during DONE is not accepted; it is accepted in the following IDLE cycle.
- stop=1 in RUN:
  - Next edge: IDLE, busy=0, valid=0, X=Y=0, vec_idx=0, done stays 0.
  - pasadas keeps its partial count until the next start.
- Latency from start to first vector: 1 cycle.
- Run length with N_PASADAS=N>0: 4*N*HOLD_CYCLES cycles of busy, then the done pulse.

Test Plan:
- Reset then idle: assert rst for 2 cycles, release, hold start=0 for 20 cycles -> X=Y=0, valid=busy=done=0, pasadas=0 throughout.
- Binary sweep (HOLD_CYCLES=10, N_PASADAS=1, modo=0): start pulse at edge k -> (X,Y)=00@k+1, 10@k+11, 01@k+21, 11@k+31; nuevo pulses at exactly those edges; busy high k+1..k+40; done=1 only at k+41 with pasadas=1, valid=0.
- Gray sweep (modo=1, HOLD_CYCLES=1, N_PASADAS=2): (X,Y)=00,10,11,01,00,10,11,01 on consecutive cycles; nuevo high every cycle; done at cycle 9 after start; pasadas=2.
- Abort: stop=1 at cycle 15 of a HOLD_CYCLES=10 binary run -> next edge busy=0, valid=0, X=Y=0, no done pulse, pasadas=0; a new start restarts from vector 0.
- Simultaneous and ignored inputs: start=stop=1 in IDLE -> stays IDLE. start held high through RUN and DONE -> exactly one run completes, then a new run begins on the edge after the IDLE cycle. modo toggled mid-run -> sequence unchanged.
- Reset mid-run: rst=1 at vector 2 -> all outputs return to reset values on the next edge. Continuous mode (N_PASADAS=0, HOLD_CYCLES=1): after 1024 cycles pasadas has wrapped to 0 and done has never pulsed.
